dshot_frame_rx: RTL



---
 rtl/dshot_frame_rx_if.sv | 34 +++
 rtl/dshot_frame_rx.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/dshot_frame_rx_if.sv
// Bus bundle between the DSHOT frame receiver and whatever consumes its results.
// master drives the serial line and enable; slave (the receiver) drives the decoded results.
interface dshot_frame_rx_if;
    logic        i_dshot;
    logic        i_enable;
    logic [10:0] o_throttle;
    logic        o_telem;
    logic        o_valid;
    logic        o_crc_err;
    logic        o_frame_err;
    logic [15:0] o_good_cnt;

    modport master (
        output i_dshot,
        output i_enable,
        input  o_throttle,
        input  o_telem,
        input  o_valid,
        input  o_crc_err,
        input  o_frame_err,
        input  o_good_cnt
    );

    modport slave (
        input  i_dshot,
        input  i_enable,
        output o_throttle,
        output o_telem,
        output o_valid,
        output o_crc_err,
        output o_frame_err,
        output o_good_cnt
    );
endinterface

// File: rtl/dshot_frame_rx.sv
// DSHOT frame receiver: measures the high time of each bit on a synchronised line,
// assembles 16-bit frames MSB first, checks the 4-bit CRC and strobes out the results.
module dshot_frame_rx #(
    parameter int unsigned CLK_FREQ_HZ = 72000000,
    parameter int unsigned DSHOT_RATE  = 600,
    parameter bit          INVERT      = 1'b0
) (
    input logic             i_sys_clk,
    input logic             i_rst,
    dshot_frame_rx_if.slave bus
);
    localparam int unsigned BIT_CLKS = CLK_FREQ_HZ / (DSHOT_RATE * 1000);
    localparam int unsigned GAP_CLKS = 2 * BIT_CLKS;
    localparam int unsigned MIN_HIGH = BIT_CLKS / 8;
    localparam int unsigned THRESH   = BIT_CLKS / 2;
    localparam int unsigned CW       = $clog2(GAP_CLKS + 1);

    // The cycle in which the rise is seen is already high, so a measured high time
    // is hcnt + 1; the thresholds below are pre-decremented to compare hcnt directly.
    localparam logic [CW-1:0] CntOne    = CW'(1);
    localparam logic [CW-1:0] GapCnt    = CW'(GAP_CLKS);
    localparam logic [CW-1:0] BitCnt    = CW'(BIT_CLKS);
    localparam logic [CW-1:0] MinHighM1 = CW'(MIN_HIGH - 1);
    localparam logic [CW-1:0] ThreshM1  = CW'(THRESH - 1);

    typedef enum logic [2:0] {StWaitGap, StIdle, StHigh, StLow, StCheck} state_e;

    state_e        state_q;
    logic          sync1_q, sync2_q, line_q;
    logic          line, rise, fall;
    logic [CW-1:0] hcnt_q, lcnt_q, hcnt_inc, lcnt_inc;
    logic [15:0]   shift_q;
    logic [4:0]    idx_q, idx_inc;
    logic [3:0]    crc_calc;
    logic [10:0]   throttle_q;
    logic          telem_q, valid_q, crc_err_q, frame_err_q;
    logic [15:0]   good_cnt_q;

    // Two-flop synchroniser plus edge-detect history; reset so the corrected level reads 0
    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1_q <= INVERT;
            sync2_q <= INVERT;
            line_q  <= 1'b0;
        end else begin
            sync1_q <= bus.i_dshot;
            sync2_q <= sync1_q;
            line_q  <= line;
        end
    end

    // Polarity-corrected level, edges, counter increments and frame CRC
    always_comb begin
        line     = sync2_q ^ INVERT;
        rise     = line & ~line_q;
        fall     = ~line & line_q;
        hcnt_inc = hcnt_q + CntOne;
        lcnt_inc = lcnt_q + CntOne;
        idx_inc  = idx_q + 5'd1;
        crc_calc = shift_q[15:12] ^ shift_q[11:8] ^ shift_q[7:4];
    end

    // Frame FSM with registered result outputs; pulses default low every cycle
    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= StWaitGap;
            hcnt_q      <= '0;
            lcnt_q      <= '0;
            shift_q     <= '0;
            idx_q       <= '0;
            throttle_q  <= '0;
            telem_q     <= 1'b0;
            valid_q     <= 1'b0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            good_cnt_q  <= '0;
        end else begin
            valid_q     <= 1'b0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            if (!bus.i_enable) begin
                // Silent abort; a fresh full gap is needed after re-enable
                state_q <= StWaitGap;
                lcnt_q  <= '0;
            end else begin
                case (state_q)
                    StWaitGap: begin
                        if (line) begin
                            lcnt_q <= '0;
                        end else if (lcnt_inc == GapCnt) begin
                            state_q <= StIdle;
                        end else begin
                            lcnt_q <= lcnt_inc;
                        end
                    end
                    StIdle: begin
                        if (rise) begin
                            shift_q <= '0;
                            idx_q   <= '0;
                            hcnt_q  <= '0;
                            state_q <= StHigh;
                        end
                    end
                    StHigh: begin
                        if (fall) begin
                            if (hcnt_q < MinHighM1) begin
                                frame_err_q <= 1'b1;
                                lcnt_q      <= '0;
                                state_q     <= StWaitGap;
                            end else begin
                                shift_q <= {shift_q[14:0], (hcnt_q >= ThreshM1)};
                                idx_q   <= idx_inc;
                                if (idx_inc == 5'd16) begin
                                    state_q <= StCheck;
                                end else begin
                                    lcnt_q  <= '0;
                                    state_q <= StLow;
                                end
                            end
                        end else if (hcnt_inc == BitCnt) begin
                            // Stuck high for a whole bit period
                            frame_err_q <= 1'b1;
                            lcnt_q      <= '0;
                            state_q     <= StWaitGap;
                        end else begin
                            hcnt_q <= hcnt_inc;
                        end
                    end
                    StLow: begin
                        if (rise) begin
                            hcnt_q  <= '0;
                            state_q <= StHigh;
                        end else if (lcnt_inc == GapCnt) begin
                            // Truncated frame; the low time already counts as a gap
                            frame_err_q <= 1'b1;
                            state_q     <= StIdle;
                        end else begin
                            lcnt_q <= lcnt_inc;
                        end
                    end
                    StCheck: begin
                        if (crc_calc == shift_q[3:0]) begin
                            throttle_q <= shift_q[15:5];
                            telem_q    <= shift_q[4];
                            valid_q    <= 1'b1;
                            good_cnt_q <= good_cnt_q + 16'd1;
                        end else begin
                            crc_err_q <= 1'b1;
                        end
                        lcnt_q  <= '0;
                        state_q <= StWaitGap;
                    end
                    default: begin
                        lcnt_q  <= '0;
                        state_q <= StWaitGap;
                    end
                endcase
            end
        end
    end

    assign bus.o_throttle  = throttle_q;
    assign bus.o_telem     = telem_q;
    assign bus.o_valid     = valid_q;
    assign bus.o_crc_err   = crc_err_q;
    assign bus.o_frame_err = frame_err_q;
    assign bus.o_good_cnt  = good_cnt_q;
endmodule
